// File: rtl/key_number_entry_pkg.sv
// Shared keypad definitions: FSM state encoding, key codes and datapath width.
// The display and keypad blocks reuse these definitions.
package key_number_entry_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ENTRY   = 2'd1,
    CONVERT = 2'd2,
    HOLD    = 2'd3
  } state_e;

  localparam logic [3:0] KEY_ENTER = 4'hA;
  localparam logic [3:0] KEY_CLEAR = 4'hB;
  localparam logic [3:0] KEY_BACK  = 4'hC;

  localparam int ACC_W = 10;

endpackage

// File: rtl/key_number_entry_bcd_digit_mac.sv
// One BCD-to-binary step: acc*10 + digit, built from two shifts and an add.
module bcd_digit_mac
  import key_number_entry_pkg::*;
(
  input  logic [ACC_W-1:0] acc_i,
  input  logic [3:0]       digit_i,
  output logic [ACC_W-1:0] acc_o
);

  assign acc_o = (acc_i << 3) + (acc_i << 1) + ACC_W'(digit_i);

endmodule

// File: rtl/key_number_entry.sv
// Keypad number entry: collects up to MAX_DIGITS BCD digits, converts them
// to binary one digit per clock, and holds the result until accepted.
module key_number_entry
  import key_number_entry_pkg::*;
#(
  parameter int MAX_DIGITS = 3
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  key_valid,
  input  logic [3:0]                            key_code,
  input  logic                                  num_ready,
  output logic                                  num_valid,
  output logic [ACC_W-1:0]                      num_value,
  output logic [4*MAX_DIGITS-1:0]               digits,
  output logic [$clog2(MAX_DIGITS+1)-1:0]       digit_count,
  output logic                                  err
);

  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam int DW = 4 * MAX_DIGITS;
  localparam logic [CW-1:0] MAXC = CW'(MAX_DIGITS);
  localparam logic [CW-1:0] ONE  = CW'(1);

  state_e           state_q, state_d;
  logic [DW-1:0]    digits_q, digits_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    idx_q, idx_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] val_q, val_d;
  logic [ACC_W-1:0] mac_res;
  logic             vld_q, vld_d;
  logic             err_q, err_d;
  logic [3:0]       cur_digit;

  // Conversion walks from the most significant entered digit down to digit 0.
  assign cur_digit = digits_q[{idx_q, 2'b00} +: 4];

  bcd_digit_mac u_mac (
    .acc_i   (acc_q),
    .digit_i (cur_digit),
    .acc_o   (mac_res)
  );

  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    val_d    = val_q;
    vld_d    = vld_q;
    err_d    = 1'b0;
    case (state_q)
      IDLE, ENTRY: begin
        if (key_valid) begin
          if (key_code <= 4'd9) begin
            if (cnt_q < MAXC) begin
              digits_d = {digits_q[DW-5:0], key_code};
              cnt_d    = cnt_q + ONE;
              state_d  = ENTRY;
            end else begin
              err_d = 1'b1;
            end
          end else if (key_code == KEY_ENTER) begin
            if (state_q == ENTRY) begin
              state_d = CONVERT;
              acc_d   = '0;
              idx_d   = cnt_q - ONE;
            end else begin
              err_d = 1'b1;
            end
          end else if (key_code == KEY_CLEAR) begin
            digits_d = '0;
            cnt_d    = '0;
            state_d  = IDLE;
          end else if (key_code == KEY_BACK) begin
            if (cnt_q == '0) begin
              err_d = 1'b1;
            end else begin
              digits_d = {4'h0, digits_q[DW-1:4]};
              cnt_d    = cnt_q - ONE;
              if (cnt_q == ONE) state_d = IDLE;
            end
          end
        end
      end
      CONVERT: begin
        acc_d = mac_res;
        if (idx_q == '0) begin
          state_d = HOLD;
          vld_d   = 1'b1;
          val_d   = mac_res;
        end else begin
          idx_d = idx_q - ONE;
        end
      end
      HOLD: begin
        // Acceptance wins over any key arriving in the same cycle.
        if (num_ready) begin
          vld_d    = 1'b0;
          digits_d = '0;
          cnt_d    = '0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      digits_q <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      acc_q    <= '0;
      val_q    <= '0;
      vld_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      digits_q <= digits_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      val_q    <= val_d;
      vld_q    <= vld_d;
      err_q    <= err_d;
    end
  end

  assign num_valid   = vld_q;
  assign num_value   = val_q;
  assign digits      = digits_q;
  assign digit_count = cnt_q;
  assign err         = err_q;

endmodule

// File: tb/tb_key_number_entry.sv
// Directed bench for key_number_entry: a vector table for the key sequences
// plus hand-written HOLD-stall and reset-abort sequences.
module tb_key_number_entry;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        num_ready;
  logic        num_valid;
  logic [9:0]  num_value;
  logic [11:0] digits;
  logic [1:0]  digit_count;
  logic        err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        kv;
    logic [3:0]  code;
    logic        rdy;
    logic [25:0] exp;
  } vec_t;

  vec_t vecs[$];

  key_number_entry #(.MAX_DIGITS(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .num_ready   (num_ready),
    .num_valid   (num_valid),
    .num_value   (num_value),
    .digits      (digits),
    .digit_count (digit_count),
    .err         (err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  function automatic logic [25:0] pk(input logic vld, input int val,
                                     input logic [11:0] dig, input int cnt,
                                     input logic e);
    return {vld, 10'(val), dig, 2'(cnt), e};
  endfunction

  function automatic logic [25:0] outs();
    return {num_valid, num_value, digits, digit_count, err};
  endfunction

  task automatic add(input logic kv, input logic [3:0] code, input logic rdy,
                     input logic vld, input int val, input logic [11:0] dig,
                     input int cnt, input logic e);
    vec_t v;
    v.kv = kv; v.code = code; v.rdy = rdy; v.exp = pk(vld, val, dig, cnt, e);
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [25:0] got, input logic [25:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h (vld,val,dig,cnt,err)", name, got, want);
    end
  endtask

  task automatic step(input logic kv, input logic [3:0] code, input logic rdy);
    @(negedge clk);
    key_valid = kv; key_code = code; num_ready = rdy;
    @(posedge clk);
    #1;
    key_valid = 1'b0; num_ready = 1'b0; key_code = 4'hF;
  endtask

  initial begin
    rst = 1'b0; key_valid = 1'b0; key_code = 4'h0; num_ready = 1'b0;

    // 1,2,3,enter with ready held
    add(1,4'h1,0, 0,0,12'h001,1,0);
    add(1,4'h2,0, 0,0,12'h012,2,0);
    add(1,4'h3,0, 0,0,12'h123,3,0);
    add(1,4'hA,1, 0,0,12'h123,3,0);
    add(0,4'h0,1, 0,0,12'h123,3,0);
    add(0,4'h0,1, 0,0,12'h123,3,0);
    add(0,4'h0,1, 1,123,12'h123,3,0);
    add(0,4'h0,1, 0,123,12'h000,0,0);
    // ignored code and clear in IDLE: no err
    add(1,4'hE,0, 0,123,12'h000,0,0);
    add(1,4'hB,0, 0,123,12'h000,0,0);
    // 9,9,9,9 overflow then enter
    add(1,4'h9,0, 0,123,12'h009,1,0);
    add(1,4'h9,0, 0,123,12'h099,2,0);
    add(1,4'h9,0, 0,123,12'h999,3,0);
    add(1,4'h9,0, 0,123,12'h999,3,1);
    add(0,4'h0,0, 0,123,12'h999,3,0);
    add(1,4'hA,0, 0,123,12'h999,3,0);
    add(0,4'h0,0, 0,123,12'h999,3,0);
    add(0,4'h0,0, 0,123,12'h999,3,0);
    add(0,4'h0,0, 1,999,12'h999,3,0);
    add(0,4'h0,1, 0,999,12'h000,0,0);
    // 4,5,back,7,enter with a key dropped in CONVERT
    add(1,4'h4,0, 0,999,12'h004,1,0);
    add(1,4'h5,0, 0,999,12'h045,2,0);
    add(1,4'hC,0, 0,999,12'h004,1,0);
    add(1,4'h7,0, 0,999,12'h047,2,0);
    add(1,4'hA,0, 0,999,12'h047,2,0);
    add(1,4'h9,0, 0,999,12'h047,2,0);
    add(0,4'h0,0, 1,47,12'h047,2,0);
    add(0,4'h0,1, 0,47,12'h000,0,0);
    add(1,4'hC,0, 0,47,12'h000,0,1);
    add(0,4'h0,0, 0,47,12'h000,0,0);
    // backspace to empty returns to IDLE, so enter errs
    add(1,4'h3,0, 0,47,12'h003,1,0);
    add(1,4'hC,0, 0,47,12'h000,0,0);
    add(1,4'hA,0, 0,47,12'h000,0,1);
    // leading zeros
    add(1,4'h0,0, 0,47,12'h000,1,0);
    add(1,4'h0,0, 0,47,12'h000,2,0);
    add(1,4'h5,0, 0,47,12'h005,3,0);
    add(1,4'hA,1, 0,47,12'h005,3,0);
    add(0,4'h0,1, 0,47,12'h005,3,0);
    add(0,4'h0,1, 0,47,12'h005,3,0);
    add(0,4'h0,1, 1,5,12'h005,3,0);
    add(0,4'h0,1, 0,5,12'h000,0,0);
    // 2,clear,enter
    add(1,4'h2,0, 0,5,12'h002,1,0);
    add(1,4'hB,0, 0,5,12'h000,0,0);
    add(1,4'hA,0, 0,5,12'h000,0,1);
    add(0,4'h0,0, 0,5,12'h000,0,0);

    #3;
    chk("reset_state", outs(), pk(0,0,12'h000,0,0));
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].kv, vecs[i].code, vecs[i].rdy);
      chk($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end

    // HOLD stall: ready low for 10 cycles, key 3 dropped
    step(1, 4'h8, 0);
    chk("hold_digit8", outs(), pk(0,5,12'h008,1,0));
    step(1, 4'hA, 0);
    step(0, 4'h0, 0);
    chk("hold_enter", outs(), pk(1,8,12'h008,1,0));
    for (int c = 0; c < 10; c++) begin
      step(c == 3, 4'h3, 0);
      chk($sformatf("hold_stable%0d", c), outs(), pk(1,8,12'h008,1,0));
    end
    step(1, 4'h5, 1);
    chk("hold_accept_key", outs(), pk(0,8,12'h000,0,0));
    step(0, 4'h0, 0);
    chk("hold_after", outs(), pk(0,8,12'h000,0,0));

    // reset mid-CONVERT aborts the number
    step(1, 4'h6, 0);
    chk("rst_digit6", outs(), pk(0,8,12'h006,1,0));
    step(1, 4'hA, 0);
    #2 rst = 1'b0;
    #1 chk("rst_async", outs(), pk(0,0,12'h000,0,0));
    @(posedge clk);
    #1 chk("rst_held", outs(), pk(0,0,12'h000,0,0));
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step(0, 4'h0, 0);
      chk($sformatf("rst_novalid%0d", c), outs(), pk(0,0,12'h000,0,0));
    end
    step(1, 4'hA, 0);
    chk("idle_enter_err", outs(), pk(0,0,12'h000,0,1));
    step(0, 4'h0, 0);
    chk("idle_enter_err_end", outs(), pk(0,0,12'h000,0,0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
